fetch_pc_ctrl: RTL and testbench

//  Sequencer for the IF stage of the 5-stage pipeline. Owns the PC register and drives the fetch stage's stall input.

---
 rtl/fetch_pc_ctrl_if.sv | 29 ++
 rtl/fetch_pc_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// Bus between the IF-stage sequencer and the rest of the pipeline.
// master: the pipeline side that supplies hazard and memory inputs.
// slave: the sequencer, which owns the PC and the stall/flush controls.
interface fetch_pc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ijmpMem;
  logic [31:0]      jmpTarget;
  logic             imemReady;
  logic [31:0]      IFIDIR;
  logic [31:0]      IDEXIR;
  logic [31:0]      PC;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             fetchErr;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport master (
    output ijmpMem, jmpTarget, imemReady, IFIDIR, IDEXIR,
    input  PC, stall, bubble, flush, fetchErr, stallCnt, flushCnt
  );

  modport slave (
    input  ijmpMem, jmpTarget, imemReady, IFIDIR, IDEXIR,
    output PC, stall, bubble, flush, fetchErr, stallCnt, flushCnt
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// IF-stage sequencer: owns the PC, stalls on load-use hazards and slow
// instruction memory, and redirects on jumps resolved in MEM. Tracks how
// long the memory has been stalling (sticky timeout error), and keeps
// saturating perf counters for stall and flush cycles.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MISS_TIMEOUT = 16,
  parameter int          CNT_W        = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_pc_ctrl_if.slave bus
);

  localparam int MC_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [MC_W-1:0] MISS_TO  = MC_W'(MISS_TIMEOUT);
  localparam logic [MC_W-1:0] MISS_ONE = MC_W'(1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic {RUN, MISS} state_t;

  state_t           state_q,     state_d;
  logic [31:0]      pc_q,        pc_d;
  logic [MC_W-1:0]  miss_cnt_q,  miss_cnt_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] ex_op, id_op;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       id_reads_rt;
  logic       load_use;
  logic       stall;

  // The opcode and register fields are all the hazard check needs; the rest
  // of each instruction word is ignored.
  logic unused_ir;
  assign unused_ir = ^{bus.IDEXIR[25:21], bus.IDEXIR[15:0], bus.IFIDIR[15:0]};

  assign ex_op = bus.IDEXIR[31:26];
  assign ex_rt = bus.IDEXIR[20:16];
  assign id_op = bus.IFIDIR[31:26];
  assign id_rs = bus.IFIDIR[25:21];
  assign id_rt = bus.IFIDIR[20:16];

  // Load-use hazard: a lw in EX writes a register the ID instruction reads.
  // rt is only a source for R-type, sw and beq; $0 never creates a hazard.
  always_comb begin
    id_reads_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);
    load_use    = (ex_op == OP_LW) && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_reads_rt && (ex_rt == id_rt)));
  end

  // A jump in MEM wins over everything: it squashes younger work, so there
  // is no point stalling for a hazard or waiting on the old fetch.
  assign stall      = !bus.ijmpMem && (load_use || !bus.imemReady);
  assign bus.stall  = stall;
  assign bus.bubble = stall;
  assign bus.flush  = bus.ijmpMem;

  // Next PC, miss tracking FSM, sticky error and perf counters.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bus.ijmpMem)  pc_d = bus.jmpTarget;
    else if (!stall)  pc_d = pc_q + 32'd4;

    case (state_q)
      RUN: begin
        if (!bus.ijmpMem && !bus.imemReady) begin
          state_d    = MISS;
          miss_cnt_d = MISS_ONE;
        end
      end
      MISS: begin
        if (bus.ijmpMem || bus.imemReady) begin
          state_d    = RUN;
          miss_cnt_d = '0;
        end else if (miss_cnt_q != MISS_TO) begin
          miss_cnt_d = miss_cnt_q + MISS_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        miss_cnt_d = '0;
      end
    endcase

    fetch_err_d = fetch_err_q || (miss_cnt_d == MISS_TO);

    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bus.ijmpMem && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // All sequencer state, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      state_q     <= RUN;
      miss_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      state_q     <= state_d;
      miss_cnt_q  <= miss_cnt_d;
      fetch_err_q <= fetch_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.fetchErr = fetch_err_q;
  assign bus.stallCnt = stall_cnt_q;
  assign bus.flushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl. Counters are narrowed to 4 bits so
// saturation is reachable in a few cycles.
module tb_fetch_pc_ctrl;

  localparam int CW = 4;

  // Instruction encodings used as stimulus.
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] LW_5     = 32'h8C25_0000; // lw   $5,0($1)
  localparam logic [31:0] LW_0     = 32'h8C20_0000; // lw   $0,0($1)
  localparam logic [31:0] ADD_5    = 32'h00A2_3020; // add  $6,$5,$2
  localparam logic [31:0] ADD_0    = 32'h0002_3020; // add  $6,$0,$2
  localparam logic [31:0] SW_5     = 32'hAC45_0000; // sw   $5,0($2)
  localparam logic [31:0] ADDI_5   = 32'h2045_0001; // addi $5,$2,1

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_pc_ctrl_if #(.CNT_W(CW)) bus ();

  fetch_pc_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .MISS_TIMEOUT(16),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample registered outputs just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ijmpMem   = 1'b0;
    bus.jmpTarget = 32'h0;
    bus.imemReady = 1'b1;
    bus.IFIDIR    = NOP;
    bus.IDEXIR    = NOP;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f);
    #1;
    chk({tag, ".stall"},  32'(bus.stall),  32'(s));
    chk({tag, ".bubble"}, 32'(bus.bubble), 32'(s));
    chk({tag, ".flush"},  32'(bus.flush),  32'(f));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    // Reset state
    chk("rst.pc",    bus.PC, 32'h0);
    chk("rst.err",   32'(bus.fetchErr), 32'h0);
    chk("rst.scnt",  32'(bus.stallCnt), 32'h0);
    chk("rst.fcnt",  32'(bus.flushCnt), 32'h0);
    chk_ctl("rst", 1'b0, 1'b0);
    reset = 1'b0;

    // 1: free-running fetch
    chk("run.pc0", bus.PC, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("run.pc", bus.PC, 32'(4 * i));
      chk_ctl("run", 1'b0, 1'b0);
    end
    chk("run.scnt", 32'(bus.stallCnt), 32'h0);

    // 2: lw $5 in EX, add reads $5 in ID -> one-cycle stall
    bus.IDEXIR = LW_5; bus.IFIDIR = ADD_5;
    chk_ctl("lu", 1'b1, 1'b0);
    step();
    chk("lu.pc_hold", bus.PC, 32'd16);
    chk("lu.scnt",    32'(bus.stallCnt), 32'd1);
    bus.IDEXIR = NOP;  // bubble arrived in EX
    chk_ctl("lu.clear", 1'b0, 1'b0);
    step();
    chk("lu.pc_adv", bus.PC, 32'd20);

    // 3: $0 destination never stalls; I-type rt is not a source; sw rt is
    bus.IDEXIR = LW_0; bus.IFIDIR = ADD_0;
    chk_ctl("lu.r0", 1'b0, 1'b0);
    bus.IDEXIR = LW_5; bus.IFIDIR = ADDI_5;
    chk_ctl("lu.addi", 1'b0, 1'b0);
    bus.IFIDIR = SW_5;
    chk_ctl("lu.sw", 1'b1, 1'b0);
    step();
    chk("lu.sw.pc",   bus.PC, 32'd20);
    chk("lu.sw.scnt", 32'(bus.stallCnt), 32'd2);

    // 4: jump beats load-use and memory wait in the same cycle
    bus.imemReady = 1'b0; bus.ijmpMem = 1'b1; bus.jmpTarget = 32'h40;
    chk_ctl("jmp", 1'b0, 1'b1);
    step();
    chk("jmp.pc",   bus.PC, 32'h40);
    chk("jmp.fcnt", 32'(bus.flushCnt), 32'd1);
    chk("jmp.scnt", 32'(bus.stallCnt), 32'd2);
    idle();
    step();
    chk("jmp.run", bus.PC, 32'h44);

    // 5: memory wait for exactly MISS_TIMEOUT cycles; stallCnt saturates
    bus.imemReady = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk_ctl("miss", 1'b1, 1'b0);
      step();
      chk("miss.pc",   bus.PC, 32'h44);
      chk("miss.err",  32'(bus.fetchErr), (i == 16) ? 32'd1 : 32'd0);
      chk("miss.scnt", 32'(bus.stallCnt), (2 + i > 15) ? 32'd15 : 32'(2 + i));
    end
    bus.imemReady = 1'b1;
    step();
    chk("miss.pc_adv",  bus.PC, 32'h48);
    chk("miss.err_stk", 32'(bus.fetchErr), 32'd1);
    chk("miss.scnt_sat", 32'(bus.stallCnt), 32'd15);

    // Reset asserted in the middle of a miss takes effect at once
    bus.imemReady = 1'b0;
    repeat (3) step();
    bus.imemReady = 1'b1;
    reset = 1'b1;
    #1;
    chk("rstmiss.err",  32'(bus.fetchErr), 32'd0);
    chk("rstmiss.pc",   bus.PC, 32'h0);
    chk("rstmiss.scnt", 32'(bus.stallCnt), 32'd0);
    chk("rstmiss.fcnt", 32'(bus.flushCnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rstmiss.pc_run", bus.PC, 32'h4);

    // Jump during MISS returns to RUN and restarts the miss count
    bus.imemReady = 1'b0;
    repeat (3) step();
    bus.ijmpMem = 1'b1; bus.jmpTarget = 32'h100;
    step();
    chk("jmiss.pc",   bus.PC, 32'h100);
    chk("jmiss.fcnt", 32'(bus.flushCnt), 32'd1);
    bus.ijmpMem = 1'b0;
    repeat (15) step();
    chk("jmiss.pc_hold", bus.PC, 32'h100);
    chk("jmiss.err15",   32'(bus.fetchErr), 32'd0);
    bus.imemReady = 1'b1;
    step();
    chk("jmiss.pc_adv", bus.PC, 32'h104);
    chk("jmiss.err",    32'(bus.fetchErr), 32'd0);

    // 6: PC wrap, unaligned target passthrough, flushCnt saturation
    bus.ijmpMem = 1'b1; bus.jmpTarget = 32'hFFFF_FFFC;
    step();
    chk("wrap.pre", bus.PC, 32'hFFFF_FFFC);
    bus.ijmpMem = 1'b0;
    step();
    chk("wrap.pc", bus.PC, 32'h0);
    bus.ijmpMem = 1'b1; bus.jmpTarget = 32'h41;
    step();
    chk("unal.pc", bus.PC, 32'h41);
    bus.ijmpMem = 1'b0;
    step();
    chk("unal.pc4", bus.PC, 32'h45);
    chk("unal.fcnt", 32'(bus.flushCnt), 32'd3);
    bus.ijmpMem = 1'b1; bus.jmpTarget = 32'h200;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("fsat.fcnt", 32'(bus.flushCnt), (3 + i > 15) ? 32'd15 : 32'(3 + i));
    end
    chk("fsat.pc", bus.PC, 32'h200);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
